// File: rtl/disp_pkg.sv
// Shared types and constants for the display scheduler: FSM states and the
// active-low seven-segment lookup for hex digits.
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      HOLD,
      SHOW
   } state_e;

   localparam logic [7:0] SSEG_BLANK = 8'hFF;

   // Bit order {dp,g,f,e,d,c,b,a}, active-low, decimal point off.
   localparam logic [7:0] SSEG_TABLE [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

endpackage

// File: rtl/disp_sched_if.sv
// Requester-side bundle of the display scheduler: level requests with their
// payloads, one-hot grants, and the four digit patterns for the display mux.
interface disp_sched_if #(
   parameter int NREQ = 4
);

   logic [NREQ-1:0]         req;
   logic [16*NREQ-1:0]      data;
   logic [4*NREQ-1:0]       dp;
   logic [NREQ-1:0]         ack;
   logic [7:0]              in0;
   logic [7:0]              in1;
   logic [7:0]              in2;
   logic [7:0]              in3;
   logic [$clog2(NREQ)-1:0] owner;
   logic                    busy;

   modport master (
      output req, data, dp,
      input  ack, in0, in1, in2, in3, owner, busy
   );

   modport slave (
      input  req, data, dp,
      output ack, in0, in1, in2, in3, owner, busy
   );

endinterface

// File: rtl/hex_to_sseg.sv
// One hex nibble plus decimal point to an active-low {dp,g,f,e,d,c,b,a} pattern.
module hex_to_sseg
   import disp_pkg::*;
(
   input  logic [3:0] hex,
   input  logic       dp,
   output logic [7:0] seg
);

   assign seg = {SSEG_TABLE[hex][7] & ~dp, SSEG_TABLE[hex][6:0]};

endmodule

// File: rtl/disp_sched.sv
// Round-robin display scheduler: grants one requester at a time, latches its
// hex value and decimal points, and holds it on screen for a minimum time.
module disp_sched
   import disp_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int TICK_DIV   = 100000,
   parameter int HOLD_TICKS = 250
) (
   input logic         clk,
   input logic         reset_n,
   disp_sched_if.slave bus
);

   localparam int OW = $clog2(NREQ);
   localparam int PW = $clog2(TICK_DIV + 1);
   localparam int TW = $clog2(HOLD_TICKS + 1);

   localparam logic [OW-1:0] LAST_IDX  = OW'(NREQ - 1);
   localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(HOLD_TICKS - 1);

   state_e        state_q, state_d;
   logic [OW-1:0] rr_q, rr_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [15:0]   data_q, data_d;
   logic [3:0]    dp_q, dp_d;
   logic          valid_q, valid_d;

   logic            any_req;
   logic            found;
   logic [OW-1:0]   win;
   logic [OW-1:0]   cand;
   logic            tick;
   logic            hold_done;
   logic            granting;
   logic [NREQ-1:0] ack_w;
   logic [7:0]      seg_w [4];

   assign any_req   = |bus.req;
   assign tick      = (pre_q == PRE_MAX);
   assign hold_done = tick && (tcnt_q == TICK_LAST);
   assign granting  = (state_q == LOAD) && found;

   // Round-robin search: first set request at or above rr_q, wrapping at NREQ.
   always_comb begin
      found = 1'b0;
      win   = rr_q;
      cand  = rr_q;
      for (int k = 0; k < NREQ; k++) begin
         cand = OW'((int'(rr_q) + k) % NREQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // NOTE: every signal gets its hold value before the case so no path infers a latch.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      pre_d   = pre_q;
      tcnt_d  = tcnt_q;
      data_d  = data_q;
      dp_d    = dp_q;
      valid_d = valid_q;

      unique case (state_q)
         IDLE, SHOW: begin
            if (any_req) state_d = LOAD;
         end

         LOAD: begin
            if (found) begin
               owner_d = win;
               rr_d    = (win == LAST_IDX) ? '0 : win + 1'b1;
               for (int k = 0; k < NREQ; k++) begin
                  if (win == OW'(k)) begin
                     data_d = bus.data[16*k +: 16];
                     dp_d   = bus.dp[4*k +: 4];
                  end
               end
               valid_d = 1'b1;
               pre_d   = '0;
               tcnt_d  = '0;
               state_d = HOLD;
            end else begin
               // Request withdrawn before the grant: fall back without acking.
               state_d = valid_q ? SHOW : IDLE;
            end
         end

         HOLD: begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) tcnt_d = tcnt_q + 1'b1;
            if (hold_done) state_d = any_req ? LOAD : SHOW;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the latched payload is cleared on reset as well; valid_q alone gates blanking.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rr_q    <= '0;
         owner_q <= '0;
         pre_q   <= '0;
         tcnt_q  <= '0;
         data_q  <= '0;
         dp_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         pre_q   <= pre_d;
         tcnt_q  <= tcnt_d;
         data_q  <= data_d;
         dp_q    <= dp_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      ack_w = '0;
      if (granting) ack_w[win] = 1'b1;
   end

   for (genvar j = 0; j < 4; j++) begin : g_digit
      hex_to_sseg u_hex (
         .hex (data_q[4*j +: 4]),
         .dp  (dp_q[j]),
         .seg (seg_w[j])
      );
   end

   assign bus.ack   = ack_w;
   assign bus.owner = granting ? win : owner_q;
   assign bus.busy  = (state_q == LOAD) || (state_q == HOLD);
   assign bus.in0   = valid_q ? seg_w[0] : SSEG_BLANK;
   assign bus.in1   = valid_q ? seg_w[1] : SSEG_BLANK;
   assign bus.in2   = valid_q ? seg_w[2] : SSEG_BLANK;
   assign bus.in3   = valid_q ? seg_w[3] : SSEG_BLANK;

endmodule

// File: tb/tb_disp_sched.sv
// Scoreboard bench for disp_sched: stimulus pushes predicted grants (who, when,
// what is shown); a negedge monitor pops and compares every DUT cycle.
module tb_disp_sched;

   localparam int N       = 4;
   localparam int PERIOD  = 13;
   localparam logic [7:0] SEG_TAB [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   typedef struct {
      int          idx;
      int          cyc;
      logic [31:0] pats;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   rr_m = 0;
   exp_t expq [$];

   disp_sched_if #(.NREQ(N)) bus ();

   disp_sched #(
      .NREQ       (N),
      .TICK_DIV   (4),
      .HOLD_TICKS (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   function automatic int pick(input logic [N-1:0] m, input int p);
      for (int k = 0; k < N; k++) begin
         if (m[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [31:0] pats_of(input int i);
      logic [31:0] r;
      logic [3:0]  nib;
      r = '0;
      for (int j = 0; j < 4; j++) begin
         nib = bus.data[16*i + 4*j +: 4];
         r[8*j +: 8] = bus.dp[4*i + j] ? (SEG_TAB[nib] & 8'h7F) : SEG_TAB[nib];
      end
      return r;
   endfunction

   task automatic push_grant(input int w, input int t);
      exp_t e;
      e.idx  = w;
      e.cyc  = t;
      e.pats = pats_of(w);
      expq.push_back(e);
   endtask

   task automatic wait_quiet();
      int n;
      n = 0;
      @(posedge clk); #1;
      while (bus.busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.busy) check("quiet_timeout", 32'(bus.busy), 32'd0);
   endtask

   // Requesters drop req the cycle after their ack; the new data must not reach the display.
   task automatic serve();
      logic [N-1:0] a;
      int n;
      n = 0;
      while (bus.req != 0 && n < 200) begin
         @(negedge clk);
         a = bus.ack;
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (a[i]) begin
               bus.req[i] = 1'b0;
               bus.data[16*i +: 16] = 16'($urandom);
            end
         end
         n++;
      end
      if (bus.req != 0) check("serve_timeout", 32'(bus.req), 32'd0);
   endtask

   task automatic run_batch(input logic [N-1:0] mask);
      logic [N-1:0] rem;
      int t, w;
      wait_quiet();
      rem = mask;
      t = cyc + 1;
      while (rem != 0) begin
         w = pick(rem, rr_m);
         push_grant(w, t);
         rem[w] = 1'b0;
         rr_m = (w + 1) % N;
         t += PERIOD;
      end
      bus.req = mask;
      serve();
      wait_quiet();
   endtask

   // Monitor: predicted display/busy/owner every cycle, grants popped from the scoreboard.
   initial begin
      logic [31:0] disp_exp;
      int owner_exp, busy_left;
      exp_t e;
      disp_exp = 32'hFFFF_FFFF;
      owner_exp = 0;
      busy_left = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            disp_exp = 32'hFFFF_FFFF;
            owner_exp = 0;
            busy_left = 0;
            check("rst_disp", {bus.in3, bus.in2, bus.in1, bus.in0}, disp_exp);
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_ack", 32'(bus.ack), 32'd0);
         end else if (bus.ack != 0) begin
            check("ack_onehot", 32'($countones(bus.ack)), 32'd1);
            check("disp_in_load", {bus.in3, bus.in2, bus.in1, bus.in0}, disp_exp);
            check("busy_load", 32'(bus.busy), 32'd1);
            if (expq.size() == 0) begin
               check("unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
               e = expq.pop_front();
               check("ack_idx", 32'(bus.ack), 32'(1 << e.idx));
               check("ack_cycle", 32'(cyc), 32'(e.cyc));
               check("owner_load", 32'(bus.owner), 32'(e.idx));
               disp_exp = e.pats;
               owner_exp = e.idx;
               busy_left = PERIOD - 1;
            end
         end else begin
            check("busy", 32'(bus.busy), 32'(busy_left > 0));
            check("owner", 32'(bus.owner), 32'(owner_exp));
            check("display", {bus.in3, bus.in2, bus.in1, bus.in0}, disp_exp);
            if (busy_left > 0) busy_left--;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, w, nack, n;
      reset_n  = 1'b0;
      bus.req  = '0;
      bus.data = {$urandom, $urandom};
      bus.dp   = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (50) @(posedge clk);

      // All four held: grants 0,1,2,3,0 exactly one LOAD+HOLD apart.
      wait_quiet();
      t = cyc + 1;
      for (int k = 0; k < 5; k++) begin
         w = pick(4'hF, rr_m);
         push_grant(w, t + PERIOD * k);
         rr_m = (w + 1) % N;
      end
      bus.req = 4'hF;
      nack = 0;
      n = 0;
      while (nack < 5 && n < 200) begin
         @(negedge clk);
         if (bus.ack != 0) nack++;
         n++;
      end
      if (nack < 5) check("held_acks", 32'(nack), 32'd5);
      @(posedge clk); #1;
      bus.req = '0;
      wait_quiet();

      // Single requester 1 with 1234.
      bus.data[31:16] = 16'h1234;
      bus.dp[7:4] = 4'b0000;
      run_batch(4'b0010);
      repeat (10) @(posedge clk);
      #1;
      check("show_1234", {bus.in3, bus.in2, bus.in1, bus.in0}, 32'hF9A4_B099);
      check("show_owner", 32'(bus.owner), 32'd1);

      // Requester 2 arrives three cycles into requester 0's hold: no preemption.
      wait_quiet();
      t = cyc + 1;
      push_grant(0, t);
      rr_m = 1;
      bus.req = 4'b0001;
      serve();
      repeat (2) @(posedge clk);
      #1;
      push_grant(pick(4'b0100, rr_m), t + PERIOD);
      rr_m = 3;
      bus.req[2] = 1'b1;
      serve();
      wait_quiet();

      // Decimal point on digit 0 of an all-zero value.
      bus.data[15:0] = 16'h0000;
      bus.dp[3:0] = 4'b0001;
      run_batch(4'b0001);
      #1;
      check("show_dp", {bus.in3, bus.in2, bus.in1, bus.in0}, 32'hC0C0_C040);

      // Reset in the middle of a hold, then rr must restart at 0.
      wait_quiet();
      push_grant(2, cyc + 1);
      rr_m = 3;
      bus.req = 4'b0100;
      serve();
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("async_disp", {bus.in3, bus.in2, bus.in1, bus.in0}, 32'hFFFF_FFFF);
      check("async_busy", 32'(bus.busy), 32'd0);
      check("async_ack", 32'(bus.ack), 32'd0);
      check("async_owner", 32'(bus.owner), 32'd0);
      rr_m = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      run_batch(4'b1001);

      // Random batches with random payloads.
      for (int it = 0; it < 12; it++) begin
         bus.data = {$urandom, $urandom};
         bus.dp   = 16'($urandom);
         run_batch(4'($urandom_range(1, 15)));
      end

      repeat (5) @(posedge clk);
      check("queue_drained", 32'(expq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
